// File: rtl/alu_dual_issue_if.sv
// rtl/alu_dual_issue_if.sv - instruction-pair input and ALU A/B issue bus of the dual-issue stage
interface alu_dual_issue_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 4,
  parameter int REGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in0_op, in1_op;
  logic            in0_br, in1_br;
  logic [REGW-1:0] in0_rd, in1_rd;
  logic [REGW-1:0] in0_rs1, in0_rs2, in1_rs1, in1_rs2;
  logic [XLEN-1:0] in0_d1, in0_d2, in1_d1, in1_d2;
  logic            in1_vld;
  logic [XLEN-1:0] a_result;
  logic            a_valid, b_valid;
  logic [OPW-1:0]  a_opr, b_opr;
  logic [XLEN-1:0] a_data1, a_data2, b_data1, b_data2;
  logic [REGW-1:0] a_rd, b_rd;
  logic            a_older;

  modport master (
    output in_valid, in0_op, in1_op, in0_br, in1_br, in0_rd, in1_rd,
           in0_rs1, in0_rs2, in1_rs1, in1_rs2, in0_d1, in0_d2, in1_d1, in1_d2,
           in1_vld, a_result,
    input  in_ready, a_valid, b_valid, a_opr, b_opr, a_data1, a_data2,
           b_data1, b_data2, a_rd, b_rd, a_older
  );

  modport slave (
    input  in_valid, in0_op, in1_op, in0_br, in1_br, in0_rd, in1_rd,
           in0_rs1, in0_rs2, in1_rs1, in1_rs2, in0_d1, in0_d2, in1_d1, in1_d2,
           in1_vld, a_result,
    output in_ready, a_valid, b_valid, a_opr, b_opr, a_data1, a_data2,
           b_data1, b_data2, a_rd, b_rd, a_older
  );
endinterface

// File: rtl/alu_dual_issue.sv
// rtl/alu_dual_issue.sv - steers a decoded pair onto ALU A/B, splitting on RAW or double branch
// Optional ISSUE_STATS_EN adds the stat_dual/stat_split pair counters.
module alu_dual_issue #(
  parameter int XLEN = 64,
  parameter int OPW  = 4,
  parameter int REGW = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  alu_dual_issue_if.slave bus
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0] stat_dual,
  output logic [31:0] stat_split
`endif
);

  typedef enum logic {READY, HOLD} state_t;
  state_t state, state_n;

  logic [OPW-1:0]  h_op, h_op_n;
  logic            h_br, h_br_n, h_f1, h_f1_n, h_f2, h_f2_n;
  logic [REGW-1:0] h_rd, h_rd_n;
  logic [XLEN-1:0] h_d1, h_d1_n, h_d2, h_d2_n;

  logic            a_valid_n, b_valid_n, a_older_n;
  logic [OPW-1:0]  a_opr_n, b_opr_n;
  logic [XLEN-1:0] a_data1_n, a_data2_n, b_data1_n, b_data2_n;
  logic [REGW-1:0] a_rd_n, b_rd_n;

  logic m1, m2, dep, both_br, accept, dual_inc, split_inc;

  assign bus.in_ready = (state == READY) && !flush;
  assign accept  = bus.in_valid && bus.in_ready;
  // x0 is hardwired zero, so writing it never creates a dependency
  assign m1      = (bus.in0_rd != '0) && (bus.in1_rs1 == bus.in0_rd);
  assign m2      = (bus.in0_rd != '0) && (bus.in1_rs2 == bus.in0_rd);
  assign dep     = bus.in1_vld && (m1 || m2);
  assign both_br = bus.in0_br && bus.in1_br;

  always_comb begin
    state_n   = state;
    h_op_n    = h_op;
    h_br_n    = h_br;
    h_rd_n    = h_rd;
    h_d1_n    = h_d1;
    h_d2_n    = h_d2;
    h_f1_n    = h_f1;
    h_f2_n    = h_f2;
    a_valid_n = 1'b0;
    b_valid_n = 1'b0;
    a_opr_n   = bus.a_opr;
    a_data1_n = bus.a_data1;
    a_data2_n = bus.a_data2;
    a_rd_n    = bus.a_rd;
    b_opr_n   = bus.b_opr;
    b_data1_n = bus.b_data1;
    b_data2_n = bus.b_data2;
    b_rd_n    = bus.b_rd;
    a_older_n = bus.a_older;
    dual_inc  = 1'b0;
    split_inc = 1'b0;

    if (flush) begin
      state_n = READY;
    end else if (state == HOLD) begin
      // held slot1 issues now; matched operands take ALU A's live result
      state_n   = READY;
      a_older_n = 1'b1;
      if (h_br) begin
        a_valid_n = 1'b1;
        a_opr_n   = h_op;
        a_data1_n = h_f1 ? bus.a_result : h_d1;
        a_data2_n = h_f2 ? bus.a_result : h_d2;
        a_rd_n    = h_rd;
      end else begin
        b_valid_n = 1'b1;
        b_opr_n   = h_op;
        b_data1_n = h_f1 ? bus.a_result : h_d1;
        b_data2_n = h_f2 ? bus.a_result : h_d2;
        b_rd_n    = h_rd;
      end
    end else if (accept) begin
      a_valid_n = 1'b1;
      a_opr_n   = bus.in0_op;
      a_data1_n = bus.in0_d1;
      a_data2_n = bus.in0_d2;
      a_rd_n    = bus.in0_rd;
      a_older_n = 1'b1;
      if (bus.in1_vld) begin
        if (dep || both_br) begin
          state_n   = HOLD;
          h_op_n    = bus.in1_op;
          h_br_n    = bus.in1_br;
          h_rd_n    = bus.in1_rd;
          h_d1_n    = bus.in1_d1;
          h_d2_n    = bus.in1_d2;
          h_f1_n    = m1;
          h_f2_n    = m2;
          split_inc = 1'b1;
        end else if (bus.in1_br) begin
          // only A can resolve branches, so the younger branch takes A
          a_opr_n   = bus.in1_op;
          a_data1_n = bus.in1_d1;
          a_data2_n = bus.in1_d2;
          a_rd_n    = bus.in1_rd;
          b_valid_n = 1'b1;
          b_opr_n   = bus.in0_op;
          b_data1_n = bus.in0_d1;
          b_data2_n = bus.in0_d2;
          b_rd_n    = bus.in0_rd;
          a_older_n = 1'b0;
          dual_inc  = 1'b1;
        end else begin
          b_valid_n = 1'b1;
          b_opr_n   = bus.in1_op;
          b_data1_n = bus.in1_d1;
          b_data2_n = bus.in1_d2;
          b_rd_n    = bus.in1_rd;
          dual_inc  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= READY;
      h_op        <= '0;
      h_br        <= 1'b0;
      h_rd        <= '0;
      h_d1        <= '0;
      h_d2        <= '0;
      h_f1        <= 1'b0;
      h_f2        <= 1'b0;
      bus.a_valid <= 1'b0;
      bus.b_valid <= 1'b0;
      bus.a_opr   <= '0;
      bus.b_opr   <= '0;
      bus.a_data1 <= '0;
      bus.a_data2 <= '0;
      bus.b_data1 <= '0;
      bus.b_data2 <= '0;
      bus.a_rd    <= '0;
      bus.b_rd    <= '0;
      bus.a_older <= 1'b0;
    end else begin
      state       <= state_n;
      h_op        <= h_op_n;
      h_br        <= h_br_n;
      h_rd        <= h_rd_n;
      h_d1        <= h_d1_n;
      h_d2        <= h_d2_n;
      h_f1        <= h_f1_n;
      h_f2        <= h_f2_n;
      bus.a_valid <= a_valid_n;
      bus.b_valid <= b_valid_n;
      bus.a_opr   <= a_opr_n;
      bus.b_opr   <= b_opr_n;
      bus.a_data1 <= a_data1_n;
      bus.a_data2 <= a_data2_n;
      bus.b_data1 <= b_data1_n;
      bus.b_data2 <= b_data2_n;
      bus.a_rd    <= a_rd_n;
      bus.b_rd    <= b_rd_n;
      bus.a_older <= a_older_n;
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_dual  <= '0;
      stat_split <= '0;
    end else begin
      stat_dual  <= stat_dual + {31'd0, dual_inc};
      stat_split <= stat_split + {31'd0, split_inc};
    end
  end
`endif

endmodule

// File: tb/tb_alu_dual_issue.sv
// tb/tb_alu_dual_issue.sv - directed and randomized checks of alu_dual_issue against a pair-level model
module tb_alu_dual_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_dual_issue_if #(.XLEN(64), .OPW(4), .REGW(5)) bus();

`ifdef ISSUE_STATS_EN
  logic [31:0] stat_dual, stat_split;
  alu_dual_issue dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus),
                      .stat_dual(stat_dual), .stat_split(stat_split));
`else
  alu_dual_issue dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
`endif

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [3:0]  op;
    logic        br;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] d1, d2;
  } slot_t;

  task automatic drive(input slot_t s0, input slot_t s1, input logic vld1, input logic iv);
    bus.in0_op = s0.op;  bus.in0_br = s0.br;  bus.in0_rd = s0.rd;
    bus.in0_rs1 = s0.rs1; bus.in0_rs2 = s0.rs2; bus.in0_d1 = s0.d1; bus.in0_d2 = s0.d2;
    bus.in1_op = s1.op;  bus.in1_br = s1.br;  bus.in1_rd = s1.rd;
    bus.in1_rs1 = s1.rs1; bus.in1_rs2 = s1.rs2; bus.in1_d1 = s1.d1; bus.in1_d2 = s1.d2;
    bus.in1_vld = vld1;
    bus.in_valid = iv;
  endtask

  function automatic slot_t mk(input logic [3:0] op, input logic br, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [63:0] d1, input logic [63:0] d2);
    slot_t s;
    s.op = op; s.br = br; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.d1 = d1; s.d2 = d2;
    return s;
  endfunction

  task automatic go_idle();
    bus.in_valid = 1'b0;
    bus.in1_vld  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; go_idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", bus.a_valid); end
    vectors++; if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", bus.b_valid); end
    vectors++; if (bus.a_data1 !== 64'd0 || bus.b_data2 !== 64'd0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0", bus.a_data1, bus.b_data2); end
    vectors++; if (bus.a_opr !== 4'd0 || bus.a_rd !== 5'd0 || bus.a_older !== 1'b0) begin errors++; $display("FAIL reset_misc: got opr=%h rd=%h older=%b expected 0", bus.a_opr, bus.a_rd, bus.a_older); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_independent();
    @(negedge clk);
    drive(mk(4'h0, 0, 5'd3, 5'd0, 5'd0, 64'd5, 64'd7), mk(4'h1, 0, 5'd4, 5'd1, 5'd2, 64'd9, 64'd4), 1, 1);
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    vectors++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) begin errors++; $display("FAIL indep_valid: got %b%b expected 11", bus.a_valid, bus.b_valid); end
    vectors++; if (bus.a_data1 !== 64'd5 || bus.a_data2 !== 64'd7) begin errors++; $display("FAIL indep_a_data: got %0d,%0d expected 5,7", bus.a_data1, bus.a_data2); end
    vectors++; if (bus.b_data1 !== 64'd9 || bus.b_data2 !== 64'd4) begin errors++; $display("FAIL indep_b_data: got %0d,%0d expected 9,4", bus.b_data1, bus.b_data2); end
    vectors++; if (bus.a_older !== 1'b1 || bus.a_rd !== 5'd3 || bus.b_rd !== 5'd4 || bus.b_opr !== 4'h1) begin errors++; $display("FAIL indep_tags: got older=%b ard=%0d brd=%0d bop=%h expected 1,3,4,1", bus.a_older, bus.a_rd, bus.b_rd, bus.b_opr); end
    // back-to-back second pair
    drive(mk(4'h2, 0, 5'd7, 5'd0, 5'd0, 64'd11, 64'd12), mk(4'h3, 0, 5'd8, 5'd9, 5'd10, 64'd13, 64'd14), 1, 1);
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    vectors++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1 || bus.a_data1 !== 64'd11 || bus.b_data1 !== 64'd13) begin errors++; $display("FAIL b2b_issue: got v=%b%b a1=%0d b1=%0d expected 11,11,13", bus.a_valid, bus.b_valid, bus.a_data1, bus.b_data1); end
    go_idle();
    @(negedge clk);
    vectors++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 || bus.b_data1 !== 64'd13) begin errors++; $display("FAIL idle_hold: got v=%b%b b1=%0d expected 00,13", bus.a_valid, bus.b_valid, bus.b_data1); end
  endtask

  task automatic test_raw();
    @(negedge clk);
    drive(mk(4'h0, 0, 5'd6, 5'd1, 5'd2, 64'd1, 64'd2), mk(4'h0, 0, 5'd8, 5'd6, 5'd7, 64'd0, 64'd10), 1, 1);
    bus.a_result = 64'd12;
    @(negedge clk);
    go_idle();
    #1;
    vectors++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b0) begin errors++; $display("FAIL raw_c1_valid: got %b%b expected 10", bus.a_valid, bus.b_valid); end
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL raw_c1_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    vectors++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b1) begin errors++; $display("FAIL raw_c2_valid: got %b%b expected 01", bus.a_valid, bus.b_valid); end
    vectors++; if (bus.b_data1 !== 64'd12 || bus.b_data2 !== 64'd10 || bus.b_rd !== 5'd8) begin errors++; $display("FAIL raw_c2_data: got %0d,%0d rd=%0d expected 12,10 rd=8", bus.b_data1, bus.b_data2, bus.b_rd); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_c2_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive(mk(4'h4, 0, 5'd0, 5'd1, 5'd1, 64'd21, 64'd22), mk(4'h5, 0, 5'd2, 5'd0, 5'd3, 64'd23, 64'd24), 1, 1);
    @(negedge clk);
    go_idle();
    #1;
    vectors++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1 || bus.b_data1 !== 64'd23) begin errors++; $display("FAIL x0_issue: got v=%b%b b1=%0d expected 11,23", bus.a_valid, bus.b_valid, bus.b_data1); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_swap();
    @(negedge clk);
    drive(mk(4'h0, 0, 5'd5, 5'd1, 5'd2, 64'd31, 64'd32), mk(4'h8, 1, 5'd0, 5'd3, 5'd4, 64'd33, 64'd34), 1, 1);
    @(negedge clk);
    go_idle();
    vectors++; if (bus.a_opr !== 4'h8 || bus.a_data1 !== 64'd33 || bus.b_opr !== 4'h0 || bus.b_data1 !== 64'd31) begin errors++; $display("FAIL swap_route: got aop=%h a1=%0d bop=%h b1=%0d expected 8,33,0,31", bus.a_opr, bus.a_data1, bus.b_opr, bus.b_data1); end
    vectors++; if (bus.a_older !== 1'b0 || bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) begin errors++; $display("FAIL swap_older: got older=%b v=%b%b expected 0,11", bus.a_older, bus.a_valid, bus.b_valid); end
  endtask

  task automatic test_double_branch();
    @(negedge clk);
    drive(mk(4'h8, 1, 5'd0, 5'd1, 5'd2, 64'd41, 64'd42), mk(4'h9, 1, 5'd0, 5'd3, 5'd4, 64'd43, 64'd44), 1, 1);
    @(negedge clk);
    go_idle();
    #1;
    vectors++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b0 || bus.a_opr !== 4'h8 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL dbr_c1: got v=%b%b aop=%h rdy=%b expected 10,8,0", bus.a_valid, bus.b_valid, bus.a_opr, bus.in_ready); end
    @(negedge clk);
    vectors++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b0 || bus.a_opr !== 4'h9 || bus.a_data1 !== 64'd43) begin errors++; $display("FAIL dbr_c2: got v=%b%b aop=%h a1=%0d expected 10,9,43", bus.a_valid, bus.b_valid, bus.a_opr, bus.a_data1); end
  endtask

  task automatic test_flush_hold();
    @(negedge clk);
    drive(mk(4'h0, 0, 5'd6, 5'd1, 5'd2, 64'd1, 64'd2), mk(4'h0, 0, 5'd8, 5'd6, 5'd7, 64'd0, 64'd10), 1, 1);
    @(negedge clk);
    go_idle();
    flush = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    vectors++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin errors++; $display("FAIL flush_no_issue: got %b%b expected 00", bus.a_valid, bus.b_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    vectors++; if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got b_valid=%b expected 0", bus.b_valid); end
  endtask

  task automatic test_rst_hold();
    @(negedge clk);
    drive(mk(4'h3, 0, 5'd6, 5'd1, 5'd2, 64'd51, 64'd52), mk(4'h0, 0, 5'd8, 5'd6, 5'd7, 64'd0, 64'd10), 1, 1);
    @(negedge clk);
    go_idle();
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.a_valid !== 1'b0 || bus.a_data1 !== 64'd0 || bus.a_opr !== 4'h0 || bus.a_rd !== 5'd0) begin errors++; $display("FAIL rst_hold_async: got v=%b a1=%0d op=%h rd=%0d expected all 0", bus.a_valid, bus.a_data1, bus.a_opr, bus.a_rd); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.b_valid !== 1'b0 || bus.a_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_discard: got %b%b expected 00", bus.a_valid, bus.b_valid); end
  endtask

`ifdef ISSUE_STATS_EN
  task automatic test_stats();
    pulse_reset();
    vectors++; if (stat_dual !== 32'd0 || stat_split !== 32'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", stat_dual, stat_split); end
    for (int i = 0; i < 3; i++) begin
      drive(mk(4'h1, 0, 5'd3, 5'd1, 5'd2, 64'(i), 64'd1), mk(4'h2, 0, 5'd4, 5'd5, 5'd6, 64'd2, 64'd3), 1, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      drive(mk(4'h1, 0, 5'd3, 5'd1, 5'd2, 64'd1, 64'd1), mk(4'h2, 0, 5'd4, 5'd3, 5'd6, 64'd2, 64'd3), 1, 1);
      @(negedge clk);
      go_idle();
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (stat_dual !== 32'd3) begin errors++; $display("FAIL stats_dual: got %0d expected 3", stat_dual); end
    vectors++; if (stat_split !== 32'd2) begin errors++; $display("FAIL stats_split: got %0d expected 2", stat_split); end
  endtask
`endif

  function automatic slot_t rnd_slot();
    slot_t s;
    s.op  = 4'($urandom_range(0, 15));
    s.br  = ($urandom_range(0, 3) == 0);
    s.rd  = 5'($urandom_range(0, 3));
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.d1  = {$urandom, $urandom};
    s.d2  = {$urandom, $urandom};
    return s;
  endfunction

  // Pair-level model: each accepted pair yields one or two issue events;
  // ALU fields persist until the next event targeting that ALU.
  task automatic test_random();
    slot_t s0, s1, pslot;
    logic        pend, fl, v1, iv, hz, f1, f2;
    logic [4:0]  prd;
    logic [63:0] ar;
    logic        e_av, e_bv, e_old;
    logic [3:0]  e_aop, e_bop;
    logic [63:0] e_a1, e_a2, e_b1, e_b2;
    logic [4:0]  e_ard, e_brd;
    pend = 0; prd = 0;
    e_av = 0; e_bv = 0; e_old = 0; e_aop = 0; e_bop = 0;
    e_a1 = 0; e_a2 = 0; e_b1 = 0; e_b2 = 0; e_ard = 0; e_brd = 0;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      vectors++; if (bus.a_valid !== e_av || bus.b_valid !== e_bv) begin errors++; $display("FAIL rnd_valid[%0d]: got %b%b expected %b%b", i, bus.a_valid, bus.b_valid, e_av, e_bv); end
      vectors++; if (bus.a_opr !== e_aop || bus.a_data1 !== e_a1 || bus.a_data2 !== e_a2 || bus.a_rd !== e_ard) begin errors++; $display("FAIL rnd_alu_a[%0d]: got %h %h %h %h expected %h %h %h %h", i, bus.a_opr, bus.a_data1, bus.a_data2, bus.a_rd, e_aop, e_a1, e_a2, e_ard); end
      vectors++; if (bus.b_opr !== e_bop || bus.b_data1 !== e_b1 || bus.b_data2 !== e_b2 || bus.b_rd !== e_brd) begin errors++; $display("FAIL rnd_alu_b[%0d]: got %h %h %h %h expected %h %h %h %h", i, bus.b_opr, bus.b_data1, bus.b_data2, bus.b_rd, e_bop, e_b1, e_b2, e_brd); end
      if (e_av || e_bv) begin
        vectors++; if (bus.a_older !== e_old) begin errors++; $display("FAIL rnd_older[%0d]: got %b expected %b", i, bus.a_older, e_old); end
      end
      s0 = rnd_slot(); s1 = rnd_slot();
      v1 = ($urandom_range(0, 3) != 0);
      iv = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      ar = {$urandom, $urandom};
      drive(s0, s1, v1, iv);
      bus.a_result = ar;
      flush = fl;
      #1;
      vectors++; if (bus.in_ready !== (!pend && !fl)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, bus.in_ready, !pend && !fl); end
      e_av = 0; e_bv = 0;
      if (fl) begin
        pend = 0;
      end else if (pend) begin
        f1 = (prd != 0) && (pslot.rs1 == prd);
        f2 = (prd != 0) && (pslot.rs2 == prd);
        if (pslot.br) begin
          e_av = 1; e_aop = pslot.op; e_ard = pslot.rd;
          e_a1 = f1 ? ar : pslot.d1; e_a2 = f2 ? ar : pslot.d2;
        end else begin
          e_bv = 1; e_bop = pslot.op; e_brd = pslot.rd;
          e_b1 = f1 ? ar : pslot.d1; e_b2 = f2 ? ar : pslot.d2;
        end
        e_old = 1; pend = 0;
      end else if (iv) begin
        hz = v1 && s0.rd != 0 && (s1.rs1 == s0.rd || s1.rs2 == s0.rd);
        e_av = 1; e_old = 1;
        if (v1 && !hz && s1.br && !s0.br) begin
          e_aop = s1.op; e_a1 = s1.d1; e_a2 = s1.d2; e_ard = s1.rd;
          e_bv = 1; e_bop = s0.op; e_b1 = s0.d1; e_b2 = s0.d2; e_brd = s0.rd;
          e_old = 0;
        end else begin
          e_aop = s0.op; e_a1 = s0.d1; e_a2 = s0.d2; e_ard = s0.rd;
          if (v1 && (hz || (s0.br && s1.br))) begin
            pend = 1; pslot = s1; prd = s0.rd;
          end else if (v1) begin
            e_bv = 1; e_bop = s1.op; e_b1 = s1.d1; e_b2 = s1.d2; e_brd = s1.rd;
          end
        end
      end
      @(negedge clk);
    end
    flush = 1'b0;
    go_idle();
  endtask

  initial begin
    drive(mk(4'h0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0), mk(4'h0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0), 0, 0);
    bus.a_result = 64'd0;
    test_reset();
    test_independent();
    test_raw();
    test_x0();
    test_swap();
    test_double_branch();
    test_flush_hold();
    test_rst_hold();
`ifdef ISSUE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/alu_dual_issue.md
Name: alu_dual_issue

Overview:
- Issue stage feeding the two 64-bit execution ALUs of the 2-way superscalar core.
- Accepts one decoded instruction pair per cycle and steers each slot to ALU A (branch-capable) or ALU B (arithmetic only).
- Splits a pair across two cycles on an intra-pair RAW hazard or a double branch.
- On a RAW split, forwards ALU A's result into the dependent instruction.

Parameters:
- XLEN, 64, operand/result width
- OPW, 4, ALU operation code width
- REGW, 5, architectural register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of pending and issuing work
- in_valid  in  1  pair offered
- in_ready  out  1  pair accepted when in_valid&&in_ready at rising edge
- in0_op, in1_op  in  OPW  operation code per slot (slot0 older)
- in0_br, in1_br  in  1  slot is a branch compare
- in0_rd, in1_rd  in  REGW  destination register
- in0_rs1, in0_rs2, in1_rs1, in1_rs2  in  REGW  source register indices
- in0_d1, in0_d2, in1_d1, in1_d2  in  XLEN  source operand values
- in1_vld  in  1  slot1 occupied
- a_result  in  XLEN  ALU A combinational result, forwarding source
- a_valid, b_valid  out  1  issue strobe to ALU A / ALU B
- a_opr, b_opr  out  OPW  ALU operation code
- a_data1, a_data2, b_data1, b_data2  out  XLEN  ALU operands
- a_rd, b_rd  out  REGW  destination tag for writeback
- a_older  out  1  1 = ALU A holds the older instruction of a same-cycle pair

Behaviour:
- All a_/b_ outputs are registered.
- Reset (asynchronous, immediate): every output is 0, state READY, no pending slot.
- in_ready = (state==READY) && !flush, combinational.
- States:
  - READY: no pending slot.
  - HOLD: slot1 captured; waiting one cycle.
- dep = in1_vld && in0_rd!=0 && (in1_rs1==in0_rd || in1_rs2==in0_rd). x0 never creates a hazard.
- On acceptance in READY, outputs appear the next cycle:
  - !in1_vld: slot0 to A; b_valid=0; a_older=1.
  - !dep, in1_br=0: slot0 to A, slot1 to B; a_older=1.
  - !dep, in1_br=1, in0_br=0 (swap): slot1 to A, slot0 to B; a_older=0.
  - !dep, both branches: slot0 to A; slot1 captured; go to HOLD.
  - dep: slot0 to A; slot1 captured with forward flags (rs1 match, rs2 match); go to HOLD.
- HOLD cycle: the held slot1 issues at the end-of-cycle edge.
  - Target is A if in1_br, else B.
  - Each matched operand is replaced by a_result sampled in the HOLD cycle.
  - a_older=1. Return to READY.
- Strobes last exactly one cycle; the unused ALU gets valid=0 with opr/data held at previous values.
- Throughput: 1 pair/cycle without hazards; 2 cycles per split pair. in_ready is low only during HOLD.
- flush=1: at the edge, a_valid=b_valid=0, pending slot discarded, state READY. A flush in HOLD drops slot1 and performs no forwarding.
- Reset mid-HOLD discards the pending slot.
- No downstream backpressure; the ALUs always accept.

Optional Feature:
- Macro ISSUE_STATS_EN.
- Defined:
  - Adds outputs stat_dual (32) and stat_split (32), both reset to 0.
  - stat_dual increments per pair issued in one cycle.
  - stat_split increments per pair entering HOLD.
  - Both wrap modulo 2^32 and clear on rst only, not on flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Independent pair, op0=0000 d=5,7 rd0=3; op1=0001 d=9,4 rs=1,2 rd1=4 -> next cycle a_valid=b_valid=1, a_data=5,7, b_data=9,4, a_older=1; in_ready stays 1 for back-to-back pairs.
- RAW: slot0 rd=6; slot1 rs1=6 op1=0000 d1=0 d2=10, a_result driven 12 -> cycle1: a_valid only, in_ready=0; cycle2: b_valid=1, b_data1=12, b_data2=10.
- rd0=0 with slot1 rs1=0 -> no split; both issue in the same cycle.
- Slot1 branch op 1000, slot0 add -> A gets slot1, B gets slot0, a_older=0. Both branches -> two consecutive a_valid pulses, b_valid never set.
- flush asserted during HOLD -> no issue the next cycle, in_ready=1 after. rst pulse mid-HOLD -> all outputs 0 immediately.
- With ISSUE_STATS_EN: 3 independent pairs + 2 RAW pairs -> stat_dual=3, stat_split=2.
